// File: rtl/vga_frame_monitor.sv
// ---------------------------------------------------------------------------
// vga_frame_monitor
//
// Passive monitor for a VGA-style pixel stream. It recovers the pixel
// coordinates from the HS/VS falling edges, measures line length and lines per
// frame, and locks once a complete frame with the expected timing has been
// seen. While locked it forwards active pixels with their coordinates and
// flags blanking that disagrees with the recovered raster position.
//
// Optional feature: define VGA_MON_CRC_EN to build a CRC-16-CCITT
// (poly 0x1021, init 0xFFFF, MSB first) over the 24-bit {R,G,B} of every
// forwarded pixel. The CRC is latched into frame_crc at each VS edge. Without
// the macro there is no CRC logic and frame_crc is tied to 0.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   VGA_R/G/B      8-bit pixel colour
//   VGA_HS/VGA_VS  active-low syncs
//   VGA_BLANK_n    high during active video
//   pix_x/pix_y    recovered coordinates of the forwarded sample
//   pix_valid      sample is active video while locked
//   pix_rgb        {R,G,B} of the forwarded sample
//   locked         FSM is in LOCKED
//   frame_done     one-cycle pulse at each VS edge outside SEEK
//   line_len       clk cycles between the last two HS edges (saturating)
//   frame_lines    HS edges between the last two VS edges (saturating)
//   frame_crc      CRC of the last completed frame (0 without the macro)
//   err_hlen       sticky: line length mismatch while measuring/locked
//   err_vlen       sticky: frame line-count mismatch while measuring/locked
//   err_blank      sticky: BLANK_n disagreed with raster position while locked
//   dbg_state_o    current FSM state (0 SEEK, 1 MEASURE, 2 LOCKED)
//
// Latency: inputs are registered once (S1); every pixel output is registered
// from the S1 sample, so outputs appear two clocks after the input sample.
// ---------------------------------------------------------------------------
module vga_frame_monitor #(
    parameter int HTOTAL_EXP  = 1600,
    parameter int VTOTAL_EXP  = 525,
    parameter int HACTIVE     = 1280,
    parameter int VACTIVE     = 480,
    parameter int HSYNC_START = 1312,
    parameter int VSYNC_START = 490
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  VGA_R,
    input  logic [7:0]  VGA_G,
    input  logic [7:0]  VGA_B,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    input  logic        VGA_BLANK_n,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_valid,
    output logic [23:0] pix_rgb,
    output logic        locked,
    output logic        frame_done,
    output logic [10:0] line_len,
    output logic [9:0]  frame_lines,
    output logic [15:0] frame_crc,
    output logic        err_hlen,
    output logic        err_vlen,
    output logic        err_blank,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        SEEK    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    localparam logic [10:0] X_LAST = 11'(HTOTAL_EXP - 1);
    localparam logic [10:0] X_SYNC = 11'(HSYNC_START);
    localparam logic [10:0] X_ACT  = 11'(HACTIVE);
    localparam logic [10:0] H_EXP  = 11'(HTOTAL_EXP);
    localparam logic [9:0]  Y_LAST = 10'(VTOTAL_EXP - 1);
    localparam logic [9:0]  Y_SYNC = 10'(VSYNC_START);
    localparam logic [9:0]  Y_ACT  = 10'(VACTIVE);
    localparam logic [9:0]  V_EXP  = 10'(VTOTAL_EXP);

    // S1 input register
    logic [23:0] rgb_s1_q;
    logic        hs_s1_q, vs_s1_q, blank_s1_q;
    logic        hs_prev_q, vs_prev_q;

    // raster and measurement state
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  lines_q, lines_d;
    logic        have_hs_q, have_hs_d;
    state_e      state_q, state_d;

    // output registers
    logic [10:0] pix_x_q, line_len_q, line_len_d;
    logic [9:0]  pix_y_q, frame_lines_q, frame_lines_d;
    logic [23:0] pix_rgb_q;
    logic        pix_valid_q, frame_done_q, frame_done_d;
    logic        err_hlen_q, err_hlen_d;
    logic        err_vlen_q, err_vlen_d;
    logic        err_blank_q, err_blank_d;

    // datapath decode of the S1 sample
    logic        hs_edge, vs_edge, x_wrap;
    logic [10:0] interval;
    logic [9:0]  lines_now;
    logic        hlen_bad, vlen_bad, blank_exp, valid_now;

    assign hs_edge = hs_prev_q & ~hs_s1_q;
    assign vs_edge = vs_prev_q & ~vs_s1_q;
    assign x_wrap  = (x_q == X_LAST);

    // An HS edge reloads x; only a plain increment past X_LAST is a wrap.
    assign x_d = hs_edge ? X_SYNC : (x_wrap ? 11'd0 : x_q + 11'd1);

    always_comb begin
        y_d = y_q;
        if (vs_edge) begin
            y_d = Y_SYNC;
        end else if (!hs_edge && x_wrap) begin
            y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
        end
    end

    // Cycles since the last HS edge; interval is the length ending at this sample.
    assign interval  = (hcnt_q == 11'h7FF) ? 11'h7FF : hcnt_q + 11'd1;
    assign hcnt_d    = hs_edge ? 11'd0 : interval;
    assign have_hs_d = have_hs_q | hs_edge;
    assign hlen_bad  = hs_edge && have_hs_q && (interval != H_EXP);

    // An HS edge coincident with a VS edge belongs to the frame being closed.
    assign lines_now = hs_edge ? ((lines_q == 10'h3FF) ? 10'h3FF : lines_q + 10'd1)
                               : lines_q;
    assign lines_d   = vs_edge ? 10'd0 : lines_now;
    assign vlen_bad  = vs_edge && (lines_now != V_EXP);

    assign blank_exp = (x_d < X_ACT) && (y_d < Y_ACT);
    assign valid_now = (state_q == LOCKED) && blank_s1_q;

    always_comb begin
        state_d       = state_q;
        err_hlen_d    = err_hlen_q;
        err_vlen_d    = err_vlen_q;
        err_blank_d   = err_blank_q;
        frame_done_d  = 1'b0;
        frame_lines_d = frame_lines_q;
        line_len_d    = line_len_q;

        if (hs_edge && have_hs_q) begin
            line_len_d = interval;
        end

        case (state_q)
            SEEK: begin
                if (vs_edge) begin
                    state_d = MEASURE;
                end
            end
            MEASURE, LOCKED: begin
                frame_done_d = vs_edge;
                if (vs_edge) begin
                    frame_lines_d = lines_now;
                end
                if (hlen_bad) begin
                    err_hlen_d = 1'b1;
                end
                if (vlen_bad) begin
                    err_vlen_d = 1'b1;
                end
                if (hlen_bad || vlen_bad) begin
                    state_d = SEEK;
                end else if (vs_edge) begin
                    state_d = LOCKED;
                end
                if ((state_q == LOCKED) && (blank_s1_q != blank_exp)) begin
                    err_blank_d = 1'b1;
                end
            end
            default: state_d = SEEK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_s1_q      <= '0;
            hs_s1_q       <= 1'b0;
            vs_s1_q       <= 1'b0;
            blank_s1_q    <= 1'b0;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            hcnt_q        <= '0;
            lines_q       <= '0;
            have_hs_q     <= 1'b0;
            state_q       <= SEEK;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_rgb_q     <= '0;
            pix_valid_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            err_hlen_q    <= 1'b0;
            err_vlen_q    <= 1'b0;
            err_blank_q   <= 1'b0;
        end else begin
            rgb_s1_q      <= {VGA_R, VGA_G, VGA_B};
            hs_s1_q       <= VGA_HS;
            vs_s1_q       <= VGA_VS;
            blank_s1_q    <= VGA_BLANK_n;
            hs_prev_q     <= hs_s1_q;
            vs_prev_q     <= vs_s1_q;
            x_q           <= x_d;
            y_q           <= y_d;
            hcnt_q        <= hcnt_d;
            lines_q       <= lines_d;
            have_hs_q     <= have_hs_d;
            state_q       <= state_d;
            pix_x_q       <= x_d;
            pix_y_q       <= y_d;
            pix_rgb_q     <= rgb_s1_q;
            pix_valid_q   <= valid_now;
            frame_done_q  <= frame_done_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            err_hlen_q    <= err_hlen_d;
            err_vlen_q    <= err_vlen_d;
            err_blank_q   <= err_blank_d;
        end
    end

`ifdef VGA_MON_CRC_EN
    function automatic logic [15:0] crc16_step24(input logic [15:0] crc_in,
                                                 input logic [23:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 23; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    logic [15:0] crc_acc_q, crc_acc_d, crc_upd;
    logic [15:0] frame_crc_q, frame_crc_d;

    // The closing sample is folded in before the latch; the accumulator restarts
    // at every VS edge so each latched value covers exactly one frame.
    assign crc_upd     = valid_now ? crc16_step24(crc_acc_q, rgb_s1_q) : crc_acc_q;
    assign crc_acc_d   = vs_edge ? 16'hFFFF : crc_upd;
    assign frame_crc_d = frame_done_d ? crc_upd : frame_crc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_acc_q   <= 16'hFFFF;
            frame_crc_q <= '0;
        end else begin
            crc_acc_q   <= crc_acc_d;
            frame_crc_q <= frame_crc_d;
        end
    end

    assign frame_crc = frame_crc_q;
`else
    assign frame_crc = 16'h0000;
`endif

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_valid   = pix_valid_q;
    assign pix_rgb     = pix_rgb_q;
    assign locked      = (state_q == LOCKED);
    assign frame_done  = frame_done_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign err_hlen    = err_hlen_q;
    assign err_vlen    = err_vlen_q;
    assign err_blank   = err_blank_q;
    assign dbg_state_o = state_q;

endmodule
